// File: rtl/lc4_perf_if.sv
// Trace-port bundle between lc4_processor's test_* outputs and lc4_perf_monitor.
// The CPI result signals exist only when LC4_PERF_CPI_EN is defined.
interface lc4_perf_if #(
  parameter int INSN  = 19,
  parameter int CNT_W = 32
);
  logic             gwe;
  logic [1:0]       test_stall;
  logic [INSN:0]    test_insn;
  logic             clear;
  logic [CNT_W-1:0] o_num_cycles;
  logic [CNT_W-1:0] o_num_exec;
  logic [CNT_W-1:0] o_num_cache_stall;
  logic [CNT_W-1:0] o_num_branch_stall;
  logic [CNT_W-1:0] o_num_load_stall;
  logic             o_running;
  logic             o_halted;
`ifdef LC4_PERF_CPI_EN
  logic [CNT_W-1:0] o_cpi_x1000;
  logic             o_cpi_valid;
`endif

  modport master (
    output gwe, test_stall, test_insn, clear,
    input  o_num_cycles, o_num_exec, o_num_cache_stall, o_num_branch_stall,
           o_num_load_stall, o_running, o_halted
`ifdef LC4_PERF_CPI_EN
           , o_cpi_x1000, o_cpi_valid
`endif
  );

  modport slave (
    input  gwe, test_stall, test_insn, clear,
    output o_num_cycles, o_num_exec, o_num_cache_stall, o_num_branch_stall,
           o_num_load_stall, o_running, o_halted
`ifdef LC4_PERF_CPI_EN
           , o_cpi_x1000, o_cpi_valid
`endif
  );
endinterface

// File: rtl/lc4_perf_monitor.sv
// Cycle/stall performance counters and halt detector on the LC4 trace port.
// Optional LC4_PERF_CPI_EN adds a post-halt serial divider producing CPI x1000.
module lc4_perf_monitor #(
  parameter int            INSN      = 19,
  parameter int            CNT_W     = 32,
  parameter logic [INSN:0] HALT_INSN = 20'h88000
) (
  input  logic      clk,
  input  logic      rst,
  lc4_perf_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, exe_q, exe_d, cst_q, cst_d;
  logic [CNT_W-1:0] bst_q, bst_d, lst_q, lst_d;
  logic             count_en, halt_hit;

`ifdef LC4_PERF_CPI_EN
  localparam logic [1:0] S_DIV = 2'd3;
  localparam int DW = CNT_W + 10;
  localparam int SW = $clog2(DW);

  logic [CNT_W-1:0] cpi_q, cpi_d, rem_q, rem_d, dvs_q, dvs_d;
  logic             cpiv_q, cpiv_d;
  logic [DW-1:0]    quo_q, quo_d, q_full;
  logic [SW-1:0]    step_q, step_d;
  logic [CNT_W:0]   rem_sh, diff;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    exe_d    = exe_q;
    cst_d    = cst_q;
    bst_d    = bst_q;
    lst_d    = lst_q;
    count_en = bus.gwe && (state_q == S_IDLE || state_q == S_RUN);
    halt_hit = count_en && (bus.test_stall == 2'd0) && (bus.test_insn == HALT_INSN);
`ifdef LC4_PERF_CPI_EN
    cpi_d  = cpi_q;
    cpiv_d = cpiv_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    step_d = step_q;
    rem_sh = '0;
    diff   = '0;
    q_full = '0;
`endif

    if (count_en) begin
      state_d = S_RUN;
      cyc_d   = sat_inc(cyc_q);
      // An unknown stall code still counts the cycle but no category.
      case (bus.test_stall)
        2'd0:    exe_d = sat_inc(exe_q);
        2'd1:    cst_d = sat_inc(cst_q);
        2'd2:    bst_d = sat_inc(bst_q);
        2'd3:    lst_d = sat_inc(lst_q);
        default: ;
      endcase
    end

    if (halt_hit) begin
`ifdef LC4_PERF_CPI_EN
      // Divider operands include the halt cycle itself.
      state_d = S_DIV;
      quo_d   = DW'(cyc_d) * DW'(1000);
      dvs_d   = exe_d;
      rem_d   = '0;
      step_d  = '0;
`else
      state_d = S_HALTED;
`endif
    end

`ifdef LC4_PERF_CPI_EN
    // Restoring division, one quotient bit per clock, MSB of the dividend first.
    if (state_q == S_DIV) begin
      rem_sh = {rem_q, quo_q[DW-1]};
      diff   = rem_sh - {1'b0, dvs_q};
      q_full = {quo_q[DW-2:0], ~diff[CNT_W]};
      rem_d  = diff[CNT_W] ? rem_sh[CNT_W-1:0] : diff[CNT_W-1:0];
      quo_d  = q_full;
      step_d = step_q + SW'(1);
      if (dvs_q == '0) begin
        cpi_d   = '1;
        cpiv_d  = 1'b1;
        state_d = S_HALTED;
      end else if (step_q == SW'(DW-1)) begin
        cpi_d   = (|q_full[DW-1:CNT_W]) ? '1 : q_full[CNT_W-1:0];
        cpiv_d  = 1'b1;
        state_d = S_HALTED;
      end
    end
`endif

    if (bus.clear) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      exe_d   = '0;
      cst_d   = '0;
      bst_d   = '0;
      lst_d   = '0;
`ifdef LC4_PERF_CPI_EN
      cpi_d   = '0;
      cpiv_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      exe_q   <= '0;
      cst_q   <= '0;
      bst_q   <= '0;
      lst_q   <= '0;
`ifdef LC4_PERF_CPI_EN
      cpi_q   <= '0;
      cpiv_q  <= 1'b0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      exe_q   <= exe_d;
      cst_q   <= cst_d;
      bst_q   <= bst_d;
      lst_q   <= lst_d;
`ifdef LC4_PERF_CPI_EN
      cpi_q   <= cpi_d;
      cpiv_q  <= cpiv_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      step_q  <= step_d;
`endif
    end
  end

  assign bus.o_num_cycles       = cyc_q;
  assign bus.o_num_exec         = exe_q;
  assign bus.o_num_cache_stall  = cst_q;
  assign bus.o_num_branch_stall = bst_q;
  assign bus.o_num_load_stall   = lst_q;
  assign bus.o_running          = (state_q == S_RUN);
`ifdef LC4_PERF_CPI_EN
  assign bus.o_halted    = (state_q == S_HALTED) || (state_q == S_DIV);
  assign bus.o_cpi_x1000 = cpi_q;
  assign bus.o_cpi_valid = cpiv_q;
`else
  assign bus.o_halted    = (state_q == S_HALTED);
`endif
endmodule

// File: tb/tb_lc4_perf_monitor.sv
// Bench for lc4_perf_monitor: a 32-bit and a 4-bit-counter instance share one
// stimulus stream; expected records go through a scoreboard queue.
module tb_lc4_perf_monitor;
  localparam int          CW = 32;
  localparam logic [19:0] HI = 20'h88000;
  localparam logic [19:0] NI = 20'h12345;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc4_perf_if #(.INSN(19), .CNT_W(CW)) bus ();
  lc4_perf_if #(.INSN(19), .CNT_W(4))  sif ();

  assign sif.gwe        = bus.gwe;
  assign sif.test_stall = bus.test_stall;
  assign sif.test_insn  = bus.test_insn;
  assign sif.clear      = bus.clear;

  lc4_perf_monitor #(.INSN(19), .CNT_W(CW), .HALT_INSN(HI)) u_dut (
    .clk(clk), .rst(rst), .bus(bus));
  lc4_perf_monitor #(.INSN(19), .CNT_W(4), .HALT_INSN(HI)) u_sat (
    .clk(clk), .rst(rst), .bus(sif));

  typedef struct {
    logic        gwe;
    logic [1:0]  stall;
    logic [19:0] insn;
    logic        clr;
    logic        rst;
    int          c, e, ca, b, l;
    logic        run, hlt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic g, input logic [1:0] s, input logic [19:0] in,
                              input logic cl, input int c, input int e, input int ca,
                              input int b, input int l, input logic run, input logic hlt,
                              input logic r = 1'b0);
    vec_t v;
    v.gwe = g; v.stall = s; v.insn = in; v.clr = cl; v.rst = r;
    v.c = c; v.e = e; v.ca = ca; v.b = b; v.l = l; v.run = run; v.hlt = hlt;
    return v;
  endfunction

  function automatic void add(input vec_t v);
    vecs.push_back(v);
  endfunction

  function automatic int s4(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t x;
    rst            = v.rst;
    bus.gwe        = v.gwe;
    bus.test_stall = v.stall;
    bus.test_insn  = v.insn;
    bus.clear      = v.clr;
    sb.push_back(v);
    @(posedge clk); #1;
    x = sb.pop_front();
    chk($sformatf("v%0d.cycles", idx), bus.o_num_cycles, x.c);
    chk($sformatf("v%0d.exec", idx),   bus.o_num_exec, x.e);
    chk($sformatf("v%0d.cache", idx),  bus.o_num_cache_stall, x.ca);
    chk($sformatf("v%0d.branch", idx), bus.o_num_branch_stall, x.b);
    chk($sformatf("v%0d.load", idx),   bus.o_num_load_stall, x.l);
    chk($sformatf("v%0d.running", idx), bus.o_running, x.run);
    chk($sformatf("v%0d.halted", idx),  bus.o_halted, x.hlt);
    chk($sformatf("v%0d.sat_cycles", idx), sif.o_num_cycles, s4(x.c));
    chk($sformatf("v%0d.sat_exec", idx),   sif.o_num_exec, s4(x.e));
    chk($sformatf("v%0d.sat_cache", idx),  sif.o_num_cache_stall, s4(x.ca));
    chk($sformatf("v%0d.sat_branch", idx), sif.o_num_branch_stall, s4(x.b));
    chk($sformatf("v%0d.sat_load", idx),   sif.o_num_load_stall, s4(x.l));
    chk($sformatf("v%0d.sat_running", idx), sif.o_running, x.run);
    chk($sformatf("v%0d.sat_halted", idx),  sif.o_halted, x.hlt);
  endtask

`ifdef LC4_PERF_CPI_EN
  task automatic wait_cpi(input string nm, input int main_exp, input int sat_exp);
    int w = 0;
    while (!bus.o_cpi_valid && w < CW + 12) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm, ".valid"},     bus.o_cpi_valid, 1);
    chk({nm, ".cpi"},       bus.o_cpi_x1000, main_exp);
    chk({nm, ".sat_valid"}, sif.o_cpi_valid, 1);
    chk({nm, ".sat_cpi"},   sif.o_cpi_x1000, sat_exp);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    rst = 1'b1; bus.gwe = 1'b0; bus.test_stall = 2'd0; bus.test_insn = NI; bus.clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.gwe = k[0];
      @(posedge clk); #1;
    end
    chk("rst.cycles", bus.o_num_cycles, 0);
    chk("rst.exec", bus.o_num_exec, 0);
    chk("rst.load", bus.o_num_load_stall, 0);
    chk("rst.running", bus.o_running, 0);
    chk("rst.halted", bus.o_halted, 0);
    chk("rst.sat_cycles", sif.o_num_cycles, 0);
`ifdef LC4_PERF_CPI_EN
    chk("rst.cpi", bus.o_cpi_x1000, 0);
    chk("rst.cpi_valid", bus.o_cpi_valid, 0);
`endif

    // Ten exec cycles separated by gwe=0 gaps carrying arbitrary stall codes.
    for (int i = 1; i <= 10; i++) begin
      add(mk(1'b0, 2'(i), NI, 1'b0, i-1, i-1, 0, 0, 0, (i > 1), 1'b0));
      add(mk(1'b1, 2'd0,  NI, 1'b0, i,   i,   0, 0, 0, 1'b1,    1'b0));
    end
    add(mk(1'b1, 2'd1, NI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    for (int k = 1; k <= 4; k++) add(mk(1'b1, 2'd0, NI, 1'b0, k, k, 0, 0, 0, 1'b1, 1'b0));
    add(mk(1'b0, 2'd3, NI, 1'b0, 4, 4, 0, 0, 0, 1'b1, 1'b0));
    for (int k = 1; k <= 2; k++) add(mk(1'b1, 2'd1, NI, 1'b0, 4+k, 4, k, 0, 0, 1'b1, 1'b0));
    for (int k = 1; k <= 3; k++) add(mk(1'b1, 2'd2, NI, 1'b0, 6+k, 4, 2, k, 0, 1'b1, 1'b0));
    add(mk(1'b1, 2'd3, NI, 1'b0, 10, 4, 2, 3, 1, 1'b1, 1'b0));
    // Halt encoding is ignored without gwe and counted as a stall when stalled.
    add(mk(1'b0, 2'd0, HI, 1'b0, 10, 4, 2, 3, 1, 1'b1, 1'b0));
    add(mk(1'b1, 2'd2, HI, 1'b0, 11, 4, 2, 4, 1, 1'b1, 1'b0));
    add(mk(1'b1, 2'd3, HI, 1'b0, 12, 4, 2, 4, 2, 1'b1, 1'b0));
    add(mk(1'b1, 2'd0, HI, 1'b0, 13, 5, 2, 4, 2, 1'b0, 1'b1));
    for (int k = 0; k < 5; k++)
      add(mk(1'b1, 2'(k), (k == 0) ? HI : NI, 1'b0, 13, 5, 2, 4, 2, 1'b0, 1'b1));
    add(mk(1'b0, 2'd0, NI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    add(mk(1'b1, 2'd0, HI, 1'b0, 1, 1, 0, 0, 0, 1'b0, 1'b1));
    add(mk(1'b1, 2'd0, HI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    // Saturation: the 4-bit instance pins at 15 while the cache counter keeps going.
    for (int k = 1; k <= 20; k++) add(mk(1'b1, 2'd0, NI, 1'b0, k, k, 0, 0, 0, 1'b1, 1'b0));
    add(mk(1'b1, 2'd1, NI, 1'b0, 21, 20, 1, 0, 0, 1'b1, 1'b0));
    add(mk(1'b1, 2'd1, NI, 1'b0, 22, 20, 2, 0, 0, 1'b1, 1'b0));
    add(mk(1'b1, 2'd1, NI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0));
    add(mk(1'b1, 2'd2, NI, 1'b0, 1, 0, 0, 1, 0, 1'b1, 1'b0));
    add(mk(1'b1, 2'd0, NI, 1'b0, 2, 1, 0, 1, 0, 1'b1, 1'b0));
    add(mk(1'b1, 2'd0, NI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1));
    add(mk(1'b1, 2'd3, NI, 1'b0, 1, 0, 0, 0, 1, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    idx = vecs.size();

`ifdef LC4_PERF_CPI_EN
    // 15 cycles, 10 of them exec (halt included): CPI x1000 = 1500.
    apply(mk(1'b0, 2'd0, NI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0), idx++);
    for (int k = 1; k <= 9; k++) apply(mk(1'b1, 2'd0, NI, 1'b0, k, k, 0, 0, 0, 1'b1, 1'b0), idx++);
    for (int k = 1; k <= 5; k++) apply(mk(1'b1, 2'd1, NI, 1'b0, 9+k, 9, k, 0, 0, 1'b1, 1'b0), idx++);
    apply(mk(1'b1, 2'd0, HI, 1'b0, 15, 10, 5, 0, 0, 1'b0, 1'b1), idx++);
    chk("cpi1.valid_at_halt", bus.o_cpi_valid, 0);
    chk("cpi1.sat_valid_at_halt", sif.o_cpi_valid, 0);
    wait_cpi("cpi1", 1500, 15);
    apply(mk(1'b0, 2'd0, NI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0), idx++);
    chk("clr.cpi", bus.o_cpi_x1000, 0);
    chk("clr.cpi_valid", bus.o_cpi_valid, 0);
    chk("clr.sat_cpi", sif.o_cpi_x1000, 0);
    // Halt as the very first counted cycle: exec=1, CPI x1000 = 1000.
    apply(mk(1'b1, 2'd0, HI, 1'b0, 1, 1, 0, 0, 0, 1'b0, 1'b1), idx++);
    wait_cpi("cpi2", 1000, 15);
    // Clear in the middle of a divide must leave no late result behind.
    apply(mk(1'b0, 2'd0, NI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0), idx++);
    apply(mk(1'b1, 2'd0, HI, 1'b0, 1, 1, 0, 0, 0, 1'b0, 1'b1), idx++);
    for (int k = 0; k < 3; k++) apply(mk(1'b0, 2'd0, NI, 1'b0, 1, 1, 0, 0, 0, 1'b0, 1'b1), idx++);
    apply(mk(1'b0, 2'd0, NI, 1'b1, 0, 0, 0, 0, 0, 1'b0, 1'b0), idx++);
    for (int k = 0; k < CW + 12; k++) begin
      @(posedge clk); #1;
    end
    chk("abort.cpi", bus.o_cpi_x1000, 0);
    chk("abort.cpi_valid", bus.o_cpi_valid, 0);
    chk("abort.sat_cpi_valid", sif.o_cpi_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
